// File: rtl/alu_uart_ctrl_pkg.sv
// Shared definitions for the UART/ALU frame controller.
//   - state_t    : FSM state encoding (3 bits)
//   - OP_*       : the eight legal ALU opcodes
//   - is_legal_op: legal-opcode check
package alu_uart_ctrl_pkg;

    localparam int unsigned OP_W = 6;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD = 6'h20;
    localparam logic [OP_W-1:0] OP_SUB = 6'h22;
    localparam logic [OP_W-1:0] OP_AND = 6'h24;
    localparam logic [OP_W-1:0] OP_OR  = 6'h25;
    localparam logic [OP_W-1:0] OP_XOR = 6'h26;
    localparam logic [OP_W-1:0] OP_NOR = 6'h27;
    localparam logic [OP_W-1:0] OP_SRA = 6'h03;
    localparam logic [OP_W-1:0] OP_SRL = 6'h02;

    // True when the opcode is one the ALU implements.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_timer.sv
// Clearable terminal-count timer for the inter-byte timeout.
// Ports:
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   i_clear            : restart counting from zero (has priority)
//   i_enable           : count this cycle; when low the counter returns to zero
//   o_terminal         : high while the count equals TIMEOUT_CYCLES-1
module alu_uart_ctrl_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_terminal = (cnt_q == TC_VAL);

    // Next count: clear wins, wrap at terminal, idle parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = {CW{1'b0}};
        end else if (i_enable) begin
            if (o_terminal) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Counter register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Frame controller between UART RX/TX and the ALU. Collects operand A,
// operand B and opcode bytes, presents them to the ALU, then sends the
// result to the transmitter with a one-cycle start pulse and waits for
// the transmitter to finish before accepting a new frame.
// Optional macro ALU_UART_CTRL_TIMEOUT_EN adds an inter-byte timeout.
// Ports:
//   i_clock, i_reset_n        : clock, asynchronous active-low reset
//   i_rx_data, i_rx_done_tick : received byte and its one-cycle strobe
//   i_tx_done_tick            : transmitter finished the current byte
//   i_alu_result              : combinational ALU result
//   o_alu_a, o_alu_b, o_alu_op: registered ALU operands/opcode
//   o_tx_data, o_tx_start     : byte to send and its start pulse
//   o_busy                    : high in EXEC and WAIT_TX
//   o_frame_err               : one-cycle pulse on illegal opcode/timeout
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int unsigned DBIT           = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic             i_rx_done_tick,
    input  logic             i_tx_done_tick,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic [DBIT-1:0]  o_alu_a,
    output logic [DBIT-1:0]  o_alu_b,
    output logic [NB_OP-1:0] o_alu_op,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_tx_start,
    output logic             o_busy,
    output logic             o_frame_err
);
    state_t            state_q, state_d;
    logic [DBIT-1:0]   alu_a_q, alu_a_d;
    logic [DBIT-1:0]   alu_b_q, alu_b_d;
    logic [NB_OP-1:0]  alu_op_q, alu_op_d;
    logic [DBIT-1:0]   tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic              byte_accept_s;
    logic              timeout_s;

`ifdef ALU_UART_CTRL_TIMEOUT_EN
    logic timer_en_s;
    logic timer_tc_s;

    assign timer_en_s = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

    alu_uart_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (byte_accept_s),
        .i_enable  (timer_en_s),
        .o_terminal(timer_tc_s)
    );

    assign timeout_s = timer_en_s && timer_tc_s;
`else
    logic [31:0] unused_timeout_cfg_s;
    logic        unused_accept_s;

    assign unused_timeout_cfg_s = 32'(TIMEOUT_CYCLES);
    assign unused_accept_s      = byte_accept_s;
    assign timeout_s            = 1'b0;
`endif

    // Next-state and datapath loads; an RX byte is checked before timeout so
    // a byte landing on the terminal cycle is accepted.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        frame_err_d   = 1'b0;
        byte_accept_s = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done_tick) begin
                    alu_a_d       = i_rx_data;
                    byte_accept_s = 1'b1;
                    state_d       = ST_WAIT_B;
                end else begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done_tick) begin
                    alu_b_d       = i_rx_data;
                    byte_accept_s = 1'b1;
                    state_d       = ST_WAIT_OP;
                end else if (timeout_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done_tick) begin
                    byte_accept_s = 1'b1;
                    if (is_legal_op(i_rx_data[NB_OP-1:0])) begin
                        alu_op_d = i_rx_data[NB_OP-1:0];
                        state_d  = ST_EXEC;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_A;
                    end
                end else if (timeout_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                // Operands have been stable for a full cycle, result is settled.
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done_tick) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
        busy_d = (state_d == ST_EXEC) || (state_d == ST_WAIT_TX);
    end

    // State and output registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_WAIT_A;
            alu_a_q     <= {DBIT{1'b0}};
            alu_b_q     <= {DBIT{1'b0}};
            alu_op_q    <= {NB_OP{1'b0}};
            tx_data_q   <= {DBIT{1'b0}};
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

endmodule
